irq_prio_ctrl: RTL
==================

# irq_prio_ctrl

Parametrised interrupt priority controller for the Z80 system bus, generalising the combinational priority encoder into a stateful controller. It edge-detects N request lines into a pending register, applies a mask, selects the highest-index eligible request and drives a registered interrupt line to the CPU. It also returns an IM2-style vector on acknowledge and tracks in-service levels until end-of-interrupt.

## Interface
- INPUT_QTY, 8: number of request lines (2..32).
- VEC_BASE, 8'h40: vector base; vector for line i = VEC_BASE + 2*i, truncated to 8 bits.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- ena  in  1  global enable.
- irq_in  in  INPUT_QTY  request lines, rising edge sets pending.
- mask_wr  in  1  load mask from mask_din.
- mask_din  in  INPUT_QTY  new mask; 1 = masked.
- ack  in  1  one-cycle interrupt-acknowledge pulse from CPU interface.
- eoi  in  1  one-cycle end-of-interrupt pulse.
- irq  out  1  registered interrupt request to CPU.
- vector  out  8  vector latched at last ack.
- mask  out  INPUT_QTY  current mask.
- pending  out  INPUT_QTY  pending requests.
- in_service  out  INPUT_QTY  levels being serviced.

## Operation
- Reset values: irq 0, vector VEC_BASE, mask all 1, pending 0, in_service 0. The edge-detect history register resets to all 1, so lines already high at reset exit are not edges.
- Edge detect: rise = irq_in & ~irq_q, with irq_q registered every cycle. pending_next = (pending & ~ack_clr) | rise. A new edge on the bit being acked the same cycle stays pending.
- Candidate = pending & ~mask. Winner = highest set index.
- Eligible: a winner exists and its index > highest in_service index, or in_service = 0.
- irq_next = ena & eligible. irq is recomputed every cycle.
- ack sampled with irq = 1:
  - vector <= VEC_BASE + 2*winner.
  - pending[winner] cleared.
  - in_service[winner] set.
  - The winner is taken from the current-cycle state.
- Spurious ack (ack with irq = 0, or ena = 0):
  - vector <= VEC_BASE + 2*INPUT_QTY, truncated to 8 bits.
  - No other state change.
- eoi clears the highest set in_service bit. eoi with in_service = 0 has no effect.
- eoi and ack in the same cycle: the eoi clear is applied first, then the ack set.
- mask_wr: mask <= mask_din. Masked pending bits are retained and fire once unmasked.
- ena = 0: irq forced low; edges still accumulate in pending; mask, eoi and rst operate normally.
- rst mid-operation discards all pending and in_service state regardless of ack/eoi in the same cycle.

## Timing
- irq_in first sampled high at edge k: pending set after edge k, irq high after edge k+1 (2-cycle latency).
- ack at edge k: vector valid after edge k. irq deasserts after edge k+1 unless another eligible request exists.
- mask_wr at edge k: mask updated after edge k; irq reflects it after edge k+1.
- eoi at edge k: in_service updated after edge k; a newly eligible irq is high after edge k+1.
- vector holds its value until the next ack.

## Configuration
- IRQ_PRIO_NEST_EN defined: nesting as above. A higher-index request preempts lower in-service levels, and in_service can hold multiple bits.
- IRQ_PRIO_NEST_EN undefined: no nesting.
  - Eligible requires in_service = 0; at most one in_service bit is set.
  - eoi clears it.
  - All other behaviour is unchanged.

## Test plan
(INPUT_QTY=8, VEC_BASE=8'h40, IRQ_PRIO_NEST_EN defined unless stated.)
- Basic request: write mask 8'h00; irq_in[3] rises → irq high 2 cycles later. ack → vector 8'h46, pending 8'h00, in_service 8'h08, irq low next cycle.
- Priority and deferral: irq_in[1] and [5] rise together → ack gives 8'h4A.
  - irq stays low, since level 1 is below in-service level 5.
  - eoi → irq high next cycle; ack → 8'h42.
- Nesting: with in_service 8'h04, irq_in[6] rises → irq; ack → 8'h4C, in_service 8'h44.
  - eoi → 8'h04.
  - Without the macro, irq stays low until in_service = 0.
- Masking: mask 8'hFF, irq_in[4] rises → pending 8'h10, irq 0. Write mask 8'hEF → irq high 1 cycle after the mask update.
- Spurious ack: ack with irq 0 → vector 8'h50; pending and in_service unchanged.
- Reset mid-operation: pending 8'h22, in_service 8'h01, irq_in held 8'hFF, rst for 1 cycle.
  - All outputs return to reset values.
  - Held-high lines produce no pending bits until they fall and rise again.

Source files
------------

// File: rtl/irq_prio_ctrl_if.sv
// irq_prio_ctrl_if: request, mask, acknowledge and status signals between the CPU side and the priority controller
interface irq_prio_ctrl_if #(parameter int INPUT_QTY = 8);
   logic                 ena;
   logic [INPUT_QTY-1:0] irq_in;
   logic                 mask_wr;
   logic [INPUT_QTY-1:0] mask_din;
   logic                 ack;
   logic                 eoi;
   logic                 irq;
   logic [7:0]           vector;
   logic [INPUT_QTY-1:0] mask;
   logic [INPUT_QTY-1:0] pending;
   logic [INPUT_QTY-1:0] in_service;
   modport master (output ena, irq_in, mask_wr, mask_din, ack, eoi,
                   input  irq, vector, mask, pending, in_service);
   modport slave  (input  ena, irq_in, mask_wr, mask_din, ack, eoi,
                   output irq, vector, mask, pending, in_service);
endinterface

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: edge-detecting, maskable, nested interrupt priority controller with IM2 vectors (IRQ_PRIO_NEST_EN enables nesting)
module irq_prio_ctrl #(
   parameter int             INPUT_QTY = 8,
   parameter logic [7:0]     VEC_BASE  = 8'h40
) (
   input  logic                 clk,
   input  logic                 rst,
   irq_prio_ctrl_if.slave       bus
);
   localparam int         IW   = (INPUT_QTY > 1) ? $clog2(INPUT_QTY) : 1;
   localparam logic [7:0] SPUR = 8'(VEC_BASE + 2 * INPUT_QTY);
   logic [INPUT_QTY-1:0] r_irq_q, r_mask, r_pending, r_in_service;
   logic                 r_irq;
   logic [7:0]           r_vector;
   logic [INPUT_QTY-1:0] w_rise, w_cand, w_win_oh, w_top_oh, w_ack_clr, w_eoi_clr;
   logic [IW-1:0]        w_win, w_top;
   logic                 w_has_win, w_any_is, w_eligible, w_ack_ok;
   logic [7:0]           w_vec_win;
   assign w_rise = bus.irq_in & ~r_irq_q;
   assign w_cand = r_pending & ~r_mask;
   // highest-index candidate and highest-index in-service level
   always_comb begin
      w_win     = '0;
      w_has_win = 1'b0;
      w_top     = '0;
      w_any_is  = 1'b0;
      for (int i = 0; i < INPUT_QTY; i++) begin
         if (w_cand[i]) begin
            w_win     = IW'(i);
            w_has_win = 1'b1;
         end
         if (r_in_service[i]) begin
            w_top    = IW'(i);
            w_any_is = 1'b1;
         end
      end
   end
`ifdef IRQ_PRIO_NEST_EN
   assign w_eligible = w_has_win && (!w_any_is || w_win > w_top);
`else
   assign w_eligible = w_has_win && !w_any_is;
`endif
   // an ack only counts when the CPU saw irq high, the block is enabled and a winner still exists
   assign w_ack_ok  = bus.ack && r_irq && bus.ena && w_has_win;
   assign w_win_oh  = INPUT_QTY'(1) << w_win;
   assign w_top_oh  = INPUT_QTY'(1) << w_top;
   assign w_ack_clr = w_ack_ok ? w_win_oh : '0;
   assign w_eoi_clr = (bus.eoi && w_any_is) ? w_top_oh : '0;
   assign w_vec_win = VEC_BASE + 8'({w_win, 1'b0});
   // state update: eoi clear is applied before the ack set; a fresh edge on the acked bit stays pending
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq_q      <= '1;
         r_irq        <= 1'b0;
         r_vector     <= VEC_BASE;
         r_mask       <= '1;
         r_pending    <= '0;
         r_in_service <= '0;
      end else begin
         r_irq_q      <= bus.irq_in;
         r_irq        <= bus.ena & w_eligible;
         r_pending    <= (r_pending & ~w_ack_clr) | w_rise;
         r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_clr;
         if (bus.mask_wr) r_mask <= bus.mask_din;
         if (bus.ack) r_vector <= w_ack_ok ? w_vec_win : SPUR;
      end
   end
   assign bus.irq        = r_irq;
   assign bus.vector     = r_vector;
   assign bus.mask       = r_mask;
   assign bus.pending    = r_pending;
   assign bus.in_service = r_in_service;
endmodule
